alu_sweep_ctrl: RTL and testbench

- Upstream sequencing stage for the 4-bit combinational ALU.
- On a start request it latches one operand pair and drives it onto the ALU's A/B inputs. It then steps the 4-bit opcode select through all 16 values, holding each for a programmable settle time.
- At the end of each hold it captures the ALU's 4-bit result and carry into a 16-entry result buffer. It also keeps a running carry count and a checksum of the results.
- Replaces the hand-stepped opcode sweep with a synthesizable, self-checking controller.

---
 rtl/alu_sweep_if.sv | 28 ++
 rtl/alu_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_sweep_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_sweep_if.sv
// Bus between the opcode-sweep controller, its requester and the 4-bit ALU.
// The controller attaches through the slave modport; the requester/ALU side uses master.
interface alu_sweep_if;
  logic       start;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_sel;
  logic [3:0] alu_out;
  logic       alu_carry;
  logic       busy;
  logic       done;
  logic [4:0] carry_count;
  logic [7:0] checksum;
  logic [3:0] rd_addr;
  logic [4:0] rd_data;

  modport slave (
    input  start, a_in, b_in, alu_out, alu_carry, rd_addr,
    output alu_a, alu_b, alu_sel, busy, done, carry_count, checksum, rd_data
  );

  modport master (
    output start, a_in, b_in, alu_out, alu_carry, rd_addr,
    input  alu_a, alu_b, alu_sel, busy, done, carry_count, checksum, rd_data
  );
endinterface

// File: rtl/alu_sweep_ctrl.sv
// Latches one operand pair, steps the ALU opcode through all 16 values and
// captures {carry, result} per opcode into a readable 16-entry buffer.
module alu_sweep_ctrl #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  alu_sweep_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     r_state, w_next_state;
  logic [3:0] r_a, w_a;
  logic [3:0] r_b, w_b;
  logic [3:0] r_sel, w_sel;
  logic [3:0] r_hold, w_hold;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic [4:0] r_carry_count, w_carry_count;
  logic [7:0] r_checksum, w_checksum;
  logic [4:0] r_rd_data;
  logic       w_wr_en;
  logic [4:0] r_buf [16];

  // NOTE: every comb output gets a default first so no path leaves a value unassigned (no latches).
  always_comb begin
    w_next_state  = r_state;
    w_a           = r_a;
    w_b           = r_b;
    w_sel         = r_sel;
    w_hold        = r_hold;
    w_busy        = r_busy;
    w_done        = r_done;
    w_carry_count = r_carry_count;
    w_checksum    = r_checksum;
    w_wr_en       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a           = bus.a_in;
          w_b           = bus.b_in;
          w_sel         = 4'd0;
          w_hold        = 4'd0;
          w_carry_count = 5'd0;
          w_checksum    = 8'd0;
          w_done        = 1'b0;
          w_busy        = 1'b1;
          w_next_state  = S_SWEEP;
        end
      end
      S_SWEEP: begin
        w_hold = r_hold + 4'd1;
        if (r_hold == HOLD_LAST) begin
          w_wr_en       = 1'b1;
          w_carry_count = r_carry_count + {4'd0, bus.alu_carry};
          w_checksum    = r_checksum + {4'd0, bus.alu_out};
          if (r_sel == 4'd15) begin
            w_next_state = S_DONE;
          end else begin
            w_sel  = r_sel + 4'd1;
            w_hold = 4'd0;
          end
        end
      end
      S_DONE: begin
        w_busy       = 1'b0;
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_a           <= 4'd0;
      r_b           <= 4'd0;
      r_sel         <= 4'd0;
      r_hold        <= 4'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_carry_count <= 5'd0;
      r_checksum    <= 8'd0;
      r_rd_data     <= 5'd0;
    end else begin
      r_state       <= w_next_state;
      r_a           <= w_a;
      r_b           <= w_b;
      r_sel         <= w_sel;
      r_hold        <= w_hold;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_carry_count <= w_carry_count;
      r_checksum    <= w_checksum;
      r_rd_data     <= r_buf[bus.rd_addr];
    end
  end

  // NOTE: the result buffer has no reset, so it maps onto plain RAM; the read above sees pre-write contents.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_buf[r_sel] <= {bus.alu_carry, bus.alu_out};
    end
  end

  assign bus.alu_a       = r_a;
  assign bus.alu_b       = r_b;
  assign bus.alu_sel     = r_sel;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.carry_count = r_carry_count;
  assign bus.checksum    = r_checksum;
  assign bus.rd_data     = r_rd_data;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Directed bench for alu_sweep_ctrl: two instances (hold 2 and hold 1), each
// driving a stub ALU computing {carry, out} = alu_a + alu_sel.
module tb_alu_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2;
  alu_sweep_if bus1 ();
  alu_sweep_if bus2 ();

  assign {bus1.alu_carry, bus1.alu_out} = {1'b0, bus1.alu_a} + {1'b0, bus1.alu_sel};
  assign {bus2.alu_carry, bus2.alu_out} = {1'b0, bus2.alu_a} + {1'b0, bus2.alu_sel};

  alu_sweep_ctrl #(.HOLD_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));
  alu_sweep_ctrl #(.HOLD_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stub-ALU reference: carries and result sum over all 16 opcodes.
  function automatic logic [7:0] exp_cc(input logic [3:0] a);
    logic [4:0] s;
    exp_cc = 8'd0;
    for (int k = 0; k < 16; k++) begin
      s = {1'b0, a} + 5'(k);
      exp_cc = exp_cc + {7'd0, s[4]};
    end
  endfunction

  function automatic logic [7:0] exp_cs(input logic [3:0] a);
    logic [4:0] s;
    exp_cs = 8'd0;
    for (int k = 0; k < 16; k++) begin
      s = {1'b0, a} + 5'(k);
      exp_cs = exp_cs + {4'd0, s[3:0]};
    end
  endfunction

  initial begin
    int found;

    // Reset with start held high
    rst1 = 1'b1; rst2 = 1'b1;
    bus1.start = 1'b1; bus1.a_in = 4'h0; bus1.b_in = 4'h0; bus1.rd_addr = 4'h0;
    bus2.start = 1'b1; bus2.a_in = 4'h0; bus2.b_in = 4'h0; bus2.rd_addr = 4'h0;
    step();
    step();
    chk("rst_busy",   8'(bus2.busy), 8'd0);
    chk("rst_done",   8'(bus2.done), 8'd0);
    chk("rst_sel",    8'(bus2.alu_sel), 8'd0);
    chk("rst_cc",     8'(bus2.carry_count), 8'd0);
    chk("rst_cs",     bus2.checksum, 8'd0);
    chk("rst_rdata",  8'(bus2.rd_data), 8'd0);
    chk("rst1_busy",  8'(bus1.busy), 8'd0);
    chk("rst1_sel",   8'(bus1.alu_sel), 8'd0);
    bus1.start = 1'b0; bus2.start = 1'b0;
    rst1 = 1'b0; rst2 = 1'b0;
    step();

    // Full sweep, hold 2, with ignored start / operand changes mid-sweep and in DONE
    bus2.a_in = 4'hA; bus2.b_in = 4'h2; bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    chk("s2_busy0", 8'(bus2.busy), 8'd1);
    chk("s2_a0",    8'(bus2.alu_a), 8'hA);
    chk("s2_b0",    8'(bus2.alu_b), 8'h2);
    chk("s2_sel0",  8'(bus2.alu_sel), 8'd0);
    for (int n = 1; n <= 34; n++) begin
      if (n == 3)  begin bus2.start = 1'b1; bus2.a_in = 4'h6; bus2.b_in = 4'hA; end
      if (n == 4)  bus2.start = 1'b0;
      if (n == 33) bus2.start = 1'b1;
      if (n == 34) bus2.start = 1'b0;
      step();
      chk($sformatf("s2_sel_%0d", n),  8'(bus2.alu_sel), (n >= 32) ? 8'd15 : 8'(n / 2));
      chk($sformatf("s2_a_%0d", n),    8'(bus2.alu_a), 8'hA);
      chk($sformatf("s2_b_%0d", n),    8'(bus2.alu_b), 8'h2);
      chk($sformatf("s2_busy_%0d", n), 8'(bus2.busy), (n <= 32) ? 8'd1 : 8'd0);
      chk($sformatf("s2_done_%0d", n), 8'(bus2.done), (n >= 33) ? 8'd1 : 8'd0);
    end
    chk("s2_cc", 8'(bus2.carry_count), 8'd10);
    chk("s2_cs", bus2.checksum, 8'h78);
    bus2.rd_addr = 4'd0;  step(); chk("s2_rd0",  8'(bus2.rd_data), 8'h0A);
    bus2.rd_addr = 4'd6;  step(); chk("s2_rd6",  8'(bus2.rd_data), 8'h10);
    bus2.rd_addr = 4'd15; step(); chk("s2_rd15", 8'(bus2.rd_data), 8'h19);

    // Reset mid-sweep at alu_sel == 5
    bus2.a_in = 4'hA; bus2.b_in = 4'h2; bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (bus2.alu_sel == 4'd5) found = 1;
      else step();
    end
    chk("mid_reach_sel5", 8'(found), 8'd1);
    chk("mid_done_clr",   8'(bus2.done), 8'd0);
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    chk("mid_busy", 8'(bus2.busy), 8'd0);
    chk("mid_sel",  8'(bus2.alu_sel), 8'd0);
    chk("mid_cc",   8'(bus2.carry_count), 8'd0);
    chk("mid_cs",   bus2.checksum, 8'd0);
    chk("mid_done", 8'(bus2.done), 8'd0);
    bus2.a_in = 4'h0; bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (bus2.done) found = 1;
    end
    chk("a0_done_seen", 8'(found), 8'd1);
    chk("a0_cc", 8'(bus2.carry_count), 8'd0);
    chk("a0_cs", bus2.checksum, 8'h78);

    // Hold 1 sweep with a_in = F
    bus1.a_in = 4'hF; bus1.b_in = 4'h3; bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    chk("s1_busy0", 8'(bus1.busy), 8'd1);
    for (int n = 1; n <= 18; n++) begin
      step();
      chk($sformatf("s1_sel_%0d", n),  8'(bus1.alu_sel), (n >= 15) ? 8'd15 : 8'(n));
      chk($sformatf("s1_busy_%0d", n), 8'(bus1.busy), (n <= 16) ? 8'd1 : 8'd0);
      chk($sformatf("s1_done_%0d", n), 8'(bus1.done), (n >= 17) ? 8'd1 : 8'd0);
    end
    chk("s1_cc", 8'(bus1.carry_count), 8'd15);
    chk("s1_cs", bus1.checksum, exp_cs(4'hF));
    chk("s1_cc_model", 8'(bus1.carry_count), exp_cc(4'hF));

    // Restart from done with a_in = 1
    bus1.a_in = 4'h1; bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    chk("rs_done", 8'(bus1.done), 8'd0);
    chk("rs_busy", 8'(bus1.busy), 8'd1);
    chk("rs_a",    8'(bus1.alu_a), 8'h1);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (bus1.done) found = 1;
    end
    chk("rs_done_seen", 8'(found), 8'd1);
    chk("rs_cc", 8'(bus1.carry_count), 8'd1);
    chk("rs_cs", bus1.checksum, exp_cs(4'h1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
